instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Instruction fetch front end that feeds the single-cycle RV32I microprocessor's `instruction` input. It owns the fetch PC and issues word reads to instruction memory through a valid/ready request port with in-order responses. Returned words are buffered in a small prefetch FIFO and handed to the core with a valid/ready handshake. A branch/jump redirect flushes the FIFO and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FIFO_DEPTH, 4, prefetch entries; power of two, 2..16; also the maximum number of outstanding memory requests
NOP_INSTR, 32'h0000_0013, value driven on `instruction` when the FIFO is empty

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  word-aligned fetch address
mem_rsp_valid  input  1  read data valid; in order, one per accepted request, latency ≥1 cycle
mem_rsp_data  input  32  read data
redirect_valid  input  1  core requests a PC change (taken branch/jump)
redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 0)
instr_valid  output  1  FIFO head valid
instr_ready  input  1  core consumes head
instruction  output  32  FIFO head instruction, or NOP_INSTR when empty
instr_pc  output  32  PC of the FIFO head, or 0 when empty

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=BOOT.
  - mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instruction=NOP_INSTR, instr_pc=0.
- States:
  - BOOT: one cycle after reset release, no request issued → RUN.
  - RUN: drop_cnt==0.
  - DRAIN: drop_cnt>0; stale responses are being discarded.
  - Redirect in RUN or DRAIN → DRAIN if the computed drop_cnt>0, else RUN. DRAIN → RUN when drop_cnt reaches 0 with no redirect that cycle.
- Credit rule:
  - mem_req_valid = (state≠BOOT) && (fifo_count + live_outstanding < FIFO_DEPTH) && !redirect_valid.
  - live_outstanding = outstanding − drop_cnt.
  - mem_req_addr = fetch_pc (registered).
- Request handshake (mem_req_valid & mem_req_ready): fetch_pc += 4; wraps 32'hFFFF_FFFC → 0. outstanding += 1.
- Response:
  - outstanding −= 1.
  - If drop_cnt>0: discard the data, drop_cnt −= 1.
  - Else: push {data, pc} into the FIFO. The pc comes from a PC FIFO captured at request time, or from rsp_pc counter logic.
  - Credit guarantees the FIFO never overflows. A response arriving with the FIFO full is an assertion failure.
- Consume: instr_valid & instr_ready pops the head. Output is the registered FIFO head. Zero-bubble push+pop in the same cycle is supported.
- Empty-to-valid latency: response in cycle N → instr_valid=1 in cycle N+1.
- Redirect (redirect_valid=1, highest priority):
  - FIFO flushed at the clock edge; any pop that cycle is ignored.
  - fetch_pc ← {redirect_pc[31:2],2'b00}.
  - drop_cnt ← outstanding − rsp_this_cycle. No request is issued in the redirect cycle.
  - A response in the redirect cycle is discarded.
  - Redirects on consecutive cycles: the last one wins; drop_cnt is recomputed each time.
- First request after reset: cycle 2 after rst rises (BOOT, then RUN).

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs `perf_fetch_cnt[31:0]` (instructions delivered to the core, +1 per instr handshake) and `perf_flush_cnt[31:0]` (+1 per redirect_valid cycle). Both are reset to 0, saturate at 32'hFFFF_FFFF, and are updated in the same cycle as the event.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package `fetch_pkg`: NOP_INSTR constant, state enum {BOOT, RUN, DRAIN}, typedef for a FIFO entry {instr[31:0], pc[31:0]}.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO with flush, push, pop, count, full and empty. The top level holds the FSM, PC, outstanding/drop counters and credit logic.

Test Plan:
- Reset then run, memory always ready, 1-cycle latency, core ready → addresses 0x0,0x4,0x8,…; instr_pc matches; first instr_valid in cycle 4 after rst rises; one instruction per cycle thereafter.
- instr_ready=0 held → exactly FIFO_DEPTH=4 requests issued; mem_req_valid stays low until one pop, then exactly one more request.
- 3 requests in flight (latency 5) then redirect_pc=0x100 → 3 responses discarded; next instr_pc=0x100 with data from address 0x100; instr_valid never shows stale data.
- redirect_pc=0x103 → treated as 0x100; redirect coinciding with mem_rsp_valid and instr_ready → response dropped, pop ignored, FIFO empty next cycle.
- RESET_PC=0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; rst pulsed low mid-DRAIN → all outputs at reset values immediately, no leftover drops afterward.
- FETCH_PERF_CNT_EN defined: 10 consumes and 2 redirects → perf_fetch_cnt=10, perf_flush_cnt=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch front end.
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush; the head is read directly from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t head_o,
    output logic [AW:0]  count_o,
    output logic         full_o,
    output logic         empty_o
);
    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, credit-limited memory requests, prefetch FIFO and redirect flush.
// Defining FETCH_PERF_CNT_EN adds saturating delivered-instruction and flush counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    import fetch_pkg::*;
    localparam int AW = $clog2(FIFO_DEPTH);

    state_e       state_q, state_d;
    logic [31:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d, new_pc;
    logic [AW:0]  out_q, out_d, drop_q, drop_d, fifo_cnt;
    logic [AW+1:0] in_use;
    logic         req_fire, push, pop, fifo_full, fifo_empty;
    fetch_entry_t head;

    assign new_pc        = redirect_pc & 32'hFFFF_FFFC;
    assign in_use        = (AW+2)'(fifo_cnt) + (AW+2)'(out_q - drop_q);
    assign mem_req_valid = state_q != BOOT && in_use < (AW+2)'(FIFO_DEPTH) && !redirect_valid;
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign push          = mem_rsp_valid && drop_q == '0 && !redirect_valid;
    assign pop           = instr_valid && instr_ready && !redirect_valid;
    assign instr_valid   = !fifo_empty;
    assign instruction   = fifo_empty ? NOP_INSTR : head.instr;
    assign instr_pc      = fifo_empty ? 32'd0 : head.pc;

    // Live requests are contiguous from the last redirect, so a counter tracks each response's PC.
    always_comb begin
        out_d    = out_q + (AW+1)'(req_fire) - (AW+1)'(mem_rsp_valid);
        drop_d   = redirect_valid ? out_q - (AW+1)'(mem_rsp_valid)
                                  : drop_q - (AW+1)'(mem_rsp_valid && drop_q != '0);
        pc_d     = redirect_valid ? new_pc : req_fire ? pc_q + 32'd4 : pc_q;
        rsp_pc_d = redirect_valid ? new_pc : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        state_d  = state_q == BOOT ? RUN : drop_d != '0 ? DRAIN : RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ('{instr: mem_rsp_data, pc: rsp_pc_q}),
        .head_o  (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule
